// File: rtl/pipe_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Optional macro PIPE_CLA_CARRY_VEC_EN adds a registered per-bit carry output.
module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
`ifdef PIPE_CLA_CARRY_VEC_EN
    ,
    output logic [WIDTH-1:0] carry
`endif
);

    localparam int NG = WIDTH / BLOCK;

    // Group generate as a flat sum of products over the group's bits.
    function automatic logic grp_gen(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p);
        logic acc;
        logic prod;
        acc = 1'b0;
        for (int k = 0; k < BLOCK; k++) begin
            prod = g[k];
            for (int m = k + 1; m < BLOCK; m++) prod = prod & p[m];
            acc = acc | prod;
        end
        return acc;
    endfunction

    logic                    s2_adv, accept;
    logic [WIDTH-1:0]        b_eff_p0, g_p0, p_p0;
    logic                    c_eff_p0;
    logic [NG-1:0]           gg_p0, gp_p0;

    logic                    vld_p1_d, vld_p1_q;
    logic [WIDTH-1:0]        a_p1_d, a_p1_q, b_p1_d, b_p1_q;
    logic [WIDTH-1:0]        g_p1_d, g_p1_q, p_p1_d, p_p1_q;
    logic                    c_p1_d, c_p1_q;
    logic [NG-1:0]           gg_p1_d, gg_p1_q, gp_p1_d, gp_p1_q;

    logic [NG:0]             cgrp_p1;
    logic [WIDTH-1:0]        cvec_p1, sum_p1;

    logic                    vld_p2_d, vld_p2_q;
    logic [WIDTH-1:0]        sum_p2_d, sum_p2_q;
    logic                    cout_p2_d, cout_p2_q, ovf_p2_d, ovf_p2_q, zero_p2_d, zero_p2_q;
`ifdef PIPE_CLA_CARRY_VEC_EN
    logic [WIDTH-1:0]        carry_p2_d, carry_p2_q;
`endif

    assign s2_adv   = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || s2_adv;
    assign accept   = in_valid && in_ready;

    // Stage 0: operand conditioning, bit and group generate/propagate
    always_comb begin
        b_eff_p0 = b ^ {WIDTH{sub}};
        c_eff_p0 = cin ^ sub;
        g_p0     = a & b_eff_p0;
        p_p0     = a ^ b_eff_p0;
        gg_p0    = '0;
        gp_p0    = '0;
        for (int j = 0; j < NG; j++) begin
            gg_p0[j] = grp_gen(g_p0[j*BLOCK +: BLOCK], p_p0[j*BLOCK +: BLOCK]);
            gp_p0[j] = &p_p0[j*BLOCK +: BLOCK];
        end
    end

    always_comb begin
        vld_p1_d = accept || (vld_p1_q && !s2_adv);
        a_p1_d   = accept ? a        : a_p1_q;
        b_p1_d   = accept ? b_eff_p0 : b_p1_q;
        c_p1_d   = accept ? c_eff_p0 : c_p1_q;
        g_p1_d   = accept ? g_p0     : g_p1_q;
        p_p1_d   = accept ? p_p0     : p_p1_q;
        gg_p1_d  = accept ? gg_p0    : gg_p1_q;
        gp_p1_d  = accept ? gp_p0    : gp_p1_q;
    end

    // Stage 1: inter-group carries, then intra-group carries, both as sums of products
    always_comb begin
        logic acc;
        logic prod;
        int   base;
        cgrp_p1    = '0;
        cvec_p1    = '0;
        cgrp_p1[0] = c_p1_q;
        for (int j = 0; j < NG; j++) begin
            acc = c_p1_q;
            for (int k = 0; k <= j; k++) acc = acc & gp_p1_q[k];
            for (int k = 0; k <= j; k++) begin
                prod = gg_p1_q[k];
                for (int m = k + 1; m <= j; m++) prod = prod & gp_p1_q[m];
                acc = acc | prod;
            end
            cgrp_p1[j+1] = acc;
        end
        for (int j = 0; j < NG; j++) begin
            base = j * BLOCK;
            for (int i = 0; i < BLOCK - 1; i++) begin
                acc = cgrp_p1[j];
                for (int m = 0; m <= i; m++) acc = acc & p_p1_q[base+m];
                for (int l = 0; l <= i; l++) begin
                    prod = g_p1_q[base+l];
                    for (int m = l + 1; m <= i; m++) prod = prod & p_p1_q[base+m];
                    acc = acc | prod;
                end
                cvec_p1[base+i] = acc;
            end
            cvec_p1[base+BLOCK-1] = cgrp_p1[j+1];
        end
        sum_p1 = a_p1_q ^ b_p1_q ^ {cvec_p1[WIDTH-2:0], c_p1_q};
    end

    always_comb begin
        vld_p2_d  = s2_adv ? vld_p1_q : vld_p2_q;
        sum_p2_d  = sum_p2_q;
        cout_p2_d = cout_p2_q;
        ovf_p2_d  = ovf_p2_q;
        zero_p2_d = zero_p2_q;
`ifdef PIPE_CLA_CARRY_VEC_EN
        carry_p2_d = carry_p2_q;
`endif
        if (vld_p1_q && s2_adv) begin
            sum_p2_d  = sum_p1;
            cout_p2_d = cvec_p1[WIDTH-1];
            ovf_p2_d  = cvec_p1[WIDTH-1] ^ cvec_p1[WIDTH-2];
            zero_p2_d = ~|sum_p1;
`ifdef PIPE_CLA_CARRY_VEC_EN
            carry_p2_d = cvec_p1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            c_p1_q    <= 1'b0;
            g_p1_q    <= '0;
            p_p1_q    <= '0;
            gg_p1_q   <= '0;
            gp_p1_q   <= '0;
            vld_p2_q  <= 1'b0;
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            zero_p2_q <= 1'b0;
`ifdef PIPE_CLA_CARRY_VEC_EN
            carry_p2_q <= '0;
`endif
        end else begin
            vld_p1_q  <= vld_p1_d;
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
            c_p1_q    <= c_p1_d;
            g_p1_q    <= g_p1_d;
            p_p1_q    <= p_p1_d;
            gg_p1_q   <= gg_p1_d;
            gp_p1_q   <= gp_p1_d;
            vld_p2_q  <= vld_p2_d;
            sum_p2_q  <= sum_p2_d;
            cout_p2_q <= cout_p2_d;
            ovf_p2_q  <= ovf_p2_d;
            zero_p2_q <= zero_p2_d;
`ifdef PIPE_CLA_CARRY_VEC_EN
            carry_p2_q <= carry_p2_d;
`endif
        end
    end

    assign out_valid = vld_p2_q;
    assign sum       = sum_p2_q;
    assign cout      = cout_p2_q;
    assign ovf       = ovf_p2_q;
    assign zero      = zero_p2_q;
`ifdef PIPE_CLA_CARRY_VEC_EN
    assign carry     = carry_p2_q;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (WIDTH=16, BLOCK=4): directed corner cases,
// backpressure, mid-flight reset and randomized traffic against an arithmetic model.
module tb_pipe_cla_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic [W-1:0] carry;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;
    logic [W-1:0] carry;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   rnd_rdy = 1'b0;

    pipe_cla_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
`ifdef PIPE_CLA_CARRY_VEC_EN
        , .carry(carry)
`endif
    );

`ifndef PIPE_CLA_CARRY_VEC_EN
    assign carry = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic icin, input logic isub);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   tot, part, mask;
        int           s;
        be    = isub ? ~ib : ib;
        ce    = icin ^ isub;
        tot   = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, ce};
        e.sum  = tot[W-1:0];
        e.cout = tot[W];
        s      = int'($signed(ia)) + int'($signed(be)) + int'(ce);
        e.ovf  = (s > 32767) || (s < -32768);
        e.zero = (tot[W-1:0] == '0);
        for (int i = 0; i < W; i++) begin
            mask = (17'd1 << (i + 1)) - 17'd1;
            part = ({1'b0, ia} & mask) + ({1'b0, be} & mask) + {{W{1'b0}}, ce};
            e.carry[i] = part[i+1];
        end
        return e;
    endfunction

    // Monitor: pops on every output handshake and checks stall stability.
    exp_t mon_e, hold_e;
    bit   hold_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_sum", 32'(sum), 32'(hold_e.sum));
                chk("hold_flags", 32'({cout, ovf, zero}), 32'({hold_e.cout, hold_e.ovf, hold_e.zero}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual sum=%h required none", sum);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(mon_e.sum));
                    chk("cout", 32'(cout), 32'(mon_e.cout));
                    chk("ovf", 32'(ovf), 32'(mon_e.ovf));
                    chk("zero", 32'(zero), 32'(mon_e.zero));
`ifdef PIPE_CLA_CARRY_VEC_EN
                    chk("carry", 32'(carry), 32'(mon_e.carry));
`endif
                end
            end
            hold_v = out_valid && !out_ready;
            hold_e.sum  = sum;
            hold_e.cout = cout;
            hold_e.ovf  = ovf;
            hold_e.zero = zero;
            hold_e.carry = carry;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Drives one operand set from posedge+1 and pushes the expectation on acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input bit dir, input exp_t dexp);
        exp_t e;
        bit   ok;
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                e = model(ia, ib, icin, isub);
                if (dir) begin
                    e.sum = dexp.sum; e.cout = dexp.cout; e.ovf = dexp.ovf; e.zero = dexp.zero;
                    e.carry = dexp.carry;
                end
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
        end
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    exp_t d;

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(16'h0000));
        chk("rst_flags", 32'({cout, ovf, zero}), 32'(3'b000));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;

        d.sum = 16'h0000; d.cout = 1'b1; d.ovf = 1'b0; d.zero = 1'b1; d.carry = 16'hFFFF;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, d);
        chk("latency_s1", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        chk("latency_s2", 32'(out_valid), 32'(1));

        d = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        d.sum = 16'h8000; d.cout = 1'b0; d.ovf = 1'b1; d.zero = 1'b0;
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, d);
        d = model(16'h0005, 16'h0007, 1'b0, 1'b1);
        d.sum = 16'hFFFE; d.cout = 1'b0; d.ovf = 1'b0; d.zero = 1'b0;
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, d);
        d = model(16'h0007, 16'h0005, 1'b0, 1'b1);
        d.sum = 16'h0002; d.cout = 1'b1; d.ovf = 1'b0; d.zero = 1'b0;
        issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, d);
        drain();

        // Backpressure: two fill the pipe, the third stalls until out_ready returns.
        out_ready = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, d);
        issue(16'h3333, 16'h0001, 1'b1, 1'b0, 1'b0, d);
        a = 16'h4000; b = 16'h0100; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(in_ready), 32'(1));
        chk("bp_out1_valid", 32'(out_valid), 32'(1));
        if (in_ready) exp_q.push_back(model(16'h4000, 16'h0100, 1'b0, 1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out2_valid", 32'(out_valid), 32'(1));
        @(negedge clk);
        chk("bp_out3_valid", 32'(out_valid), 32'(1));
        @(posedge clk);
        #1;
        drain();

        rnd_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            issue(rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, d);
            if ($urandom_range(0, 3) == 0) begin
                a = W'($urandom); b = W'($urandom);
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Mid-flight reset with both stages occupied.
        out_ready = 1'b0;
        issue(16'h0AAA, 16'h0555, 1'b0, 1'b0, 1'b0, d);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, d);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_sum", 32'(sum), 32'(0));
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width; legal values are >=4 and a multiple of BLOCK.
REQ-002 SHALL have parameter BLOCK, default 4, meaning lookahead group width; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-006 SHALL have ports a and b, input, WIDTH each: the operands.
REQ-007 SHALL have port cin, input, 1: the carry-in.
REQ-008 SHALL have port sub, input, 1: 1 selects subtract mode.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the output handshake.
REQ-010 SHALL have port sum, output, WIDTH: the result.
REQ-011 SHALL have port cout, output, 1: the carry out of bit WIDTH-1.
REQ-012 SHALL have port ovf, output, 1: signed (two's-complement) overflow.
REQ-013 SHALL have port zero, output, 1: asserted when sum == 0.

Function
REQ-014 SHALL compute effective operands b_eff = b XOR {WIDTH{sub}} and c_eff = cin XOR sub, so sub=1, cin=0 yields a-b.
REQ-015 SHALL compute per-bit g = a&b_eff and p = a^b_eff, where c[i] is the carry out of bit i, c[i] = g[i] | p[i]&c[i-1], and c[-1] = c_eff.
REQ-016 SHALL use two-level lookahead and SHALL NOT use a ripple chain: group G/P per BLOCK bits, inter-group carries from group G/P, then intra-group carries.
REQ-017 SHALL produce sum[i] = p[i]^c[i-1], cout = c[WIDTH-1] and ovf = c[WIDTH-1]^c[WIDTH-2].
REQ-018 SHALL have two pipeline stages. S1 registers a, b_eff, c_eff, g, p and group G/P together with valid s1_v. S2 is the output register holding sum, cout, ovf and zero, with out_valid.
REQ-019 SHALL accept a transaction on a rising edge when in_valid && in_ready.
REQ-020 SHALL present an operand set accepted at edge k with out_valid=1 after edge k+1.
REQ-021 SHALL drive in_ready = !s1_v || s2_adv, where s2_adv = !out_valid || out_ready; a combinational ready path is permitted.
REQ-022 SHALL load S2 from S1 when s1_v && s2_adv, and SHALL clear out_valid on a handshake with no S1 data behind it.
REQ-023 SHALL sustain one transaction per cycle when out_ready is held at 1.
REQ-024 SHALL hold the out_valid=1 payload stable until out_ready=1.
REQ-025 SHALL deliver results in acceptance order, with no loss or duplication under arbitrary out_ready patterns.
REQ-026 SHALL, on a simultaneous output handshake and input accept with both stages full, advance both stages on the same edge.
REQ-027 SHALL ignore inputs while in_valid=0 or in_ready=0; no state changes.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear s1_v, out_valid, sum, cout, ovf, zero and all S1 data registers (and carry when REQ-030 applies) to 0.
REQ-029 SHALL, when reset asserts mid-operation, discard in-flight results; in_ready reads 1 from the first cycle after rst_n rises.

Configuration
REQ-030 SHALL, with macro PIPE_CLA_CARRY_VEC_EN defined, add output port carry (WIDTH bits) registered in S2, carry[i] = c[i], aligned with sum.
REQ-031 SHALL, without PIPE_CLA_CARRY_VEC_EN, omit the port carry and its registers; all other behaviour is identical.

Verification (WIDTH=16, BLOCK=4)
REQ-032 SHALL cover reset: rst_n=0 -> out_valid=0, sum=0x0000, cout=0, ovf=0, zero=0; after release, in_ready=1.
REQ-033 SHALL cover wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1; with macro, carry=0xFFFF.
REQ-034 SHALL cover signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-035 SHALL cover subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-036 SHALL cover backpressure: out_ready=0 with three back-to-back in_valid -> two accepted, in_ready=0 on the third; then out_ready=1 -> three results in order, one per cycle.
REQ-037 SHALL cover reset mid-flight: rst_n pulsed low with S1 and S2 full -> out_valid=0 immediately; no stale result appears after release.
